// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with valid/ready handshakes on both sides and a flush abort.
module alu_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [2:0]      ctrl,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] res
);

    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam int W2 = 2 * XLEN;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_op;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [W2-1:0]   r_mc;
    logic [XLEN-1:0] r_mp;
    logic [W2-1:0]   r_acc;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_div;
    logic [XLEN-1:0] r_res;

    function automatic logic [XLEN-1:0] cneg_x(input logic neg, input logic [XLEN-1:0] v);
        return neg ? (~v + XLEN'(1)) : v;
    endfunction

    function automatic logic [W2-1:0] cneg_w(input logic neg, input logic [W2-1:0] v);
        return neg ? (~v + W2'(1)) : v;
    endfunction

    // Operand decode at acceptance
    logic            w_is_div;
    logic            w_a_sgn;
    logic            w_b_sgn;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_b_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_spec_res;

    always_comb begin
        w_is_div = ctrl[2];
        // MULH/MULHSU treat A as signed; only MULH treats B as signed
        w_a_sgn  = A[XLEN-1] & (w_is_div ? ~ctrl[0] : (ctrl[1:0] == 2'b01 || ctrl[1:0] == 2'b10));
        w_b_sgn  = B[XLEN-1] & (w_is_div ? ~ctrl[0] : (ctrl[1:0] == 2'b01));
        w_a_mag  = cneg_x(w_a_sgn, A);
        w_b_mag  = cneg_x(w_b_sgn, B);
        w_b_zero = (B == '0);
        w_ovf    = w_is_div & ~ctrl[0] & (A == {1'b1, {(XLEN-1){1'b0}}}) & (B == '1);
        w_special = w_is_div & (w_b_zero | w_ovf);
        if (w_b_zero) begin
            w_spec_res = ctrl[1] ? A : '1;
        end else begin
            w_spec_res = ctrl[1] ? '0 : A;
        end
    end

    // One iteration of each algorithm; both run every CALC cycle, r_op picks the result
    logic [W2-1:0]   w_acc_nxt;
    logic [XLEN:0]   w_rem_sh;
    logic            w_rem_ge;
    logic [XLEN-1:0] w_rem_sub;
    logic [XLEN-1:0] w_rem_nxt;
    logic [XLEN-1:0] w_quo_nxt;
    logic [W2-1:0]   w_prod;
    logic [XLEN-1:0] w_final;

    always_comb begin
        w_acc_nxt = r_acc + (r_mp[0] ? r_mc : '0);
        w_rem_sh  = {r_rem, r_quo[XLEN-1]};
        w_rem_ge  = (w_rem_sh >= {1'b0, r_div});
        // When w_rem_ge holds the true difference is below 2^XLEN, so low bits suffice
        w_rem_sub = w_rem_sh[XLEN-1:0] - r_div;
        w_rem_nxt = w_rem_ge ? w_rem_sub : w_rem_sh[XLEN-1:0];
        w_quo_nxt = {r_quo[XLEN-2:0], w_rem_ge};
        w_prod    = cneg_w(r_neg_q, w_acc_nxt);
        case (r_op)
            3'b000:                 w_final = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod[W2-1:XLEN];
            3'b100, 3'b101:         w_final = cneg_x(r_neg_q, w_quo_nxt);
            default:                w_final = cneg_x(r_neg_r, w_rem_nxt);
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) w_state_nxt = w_special ? S_DONE : S_CALC;
                S_CALC: if (r_cnt == '0) w_state_nxt = S_DONE;
                S_DONE: if (out_ready) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_op    <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_mc    <= '0;
            r_mp    <= '0;
            r_acc   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_res   <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op    <= ctrl;
                        r_neg_q <= w_a_sgn ^ w_b_sgn;
                        r_neg_r <= w_a_sgn;
                        r_mc    <= {{XLEN{1'b0}}, w_a_mag};
                        r_mp    <= w_b_mag;
                        r_acc   <= '0;
                        r_rem   <= '0;
                        r_quo   <= w_a_mag;
                        r_div   <= w_b_mag;
                        if (w_special) begin
                            r_res <= w_spec_res;
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= CW'(XLEN - 1);
                        end
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_nxt;
                    r_mc  <= {r_mc[W2-2:0], 1'b0};
                    r_mp  <= {1'b0, r_mp[XLEN-1:1]};
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    if (r_cnt == '0) begin
                        r_res <= w_final;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign res       = r_res;

endmodule
